// File: rtl/event_readout_scheduler_if.sv
// Stream bundle between the scheduler and its neighbours: event and nack
// request inputs, the MM2S command output and the datamover status return.
interface event_readout_scheduler_if;
  logic [11:0] s_evt_tdata;
  logic        s_evt_tvalid;
  logic        s_evt_tready;
  logic [47:0] s_nack_tdata;
  logic        s_nack_tvalid;
  logic        s_nack_tready;
  logic [50:0] m_req_tdata;
  logic        m_req_tvalid;
  logic        m_req_tready;
  logic [7:0]  s_sts_tdata;
  logic        s_sts_tvalid;

  modport master (
    output s_evt_tdata, s_evt_tvalid, input s_evt_tready,
    output s_nack_tdata, s_nack_tvalid, input s_nack_tready,
    input  m_req_tdata, m_req_tvalid, output m_req_tready,
    output s_sts_tdata, s_sts_tvalid
  );

  modport slave (
    input  s_evt_tdata, s_evt_tvalid, output s_evt_tready,
    input  s_nack_tdata, s_nack_tvalid, output s_nack_tready,
    output m_req_tdata, m_req_tvalid, input m_req_tready,
    input  s_sts_tdata, s_sts_tvalid
  );
endinterface

// File: rtl/event_readout_scheduler.sv
// Arbitrates full-event and nack-retransmit readout requests onto the single
// MM2S command path, bounding outstanding commands and nack bursts.
module event_readout_scheduler #(
  parameter int unsigned MAX_INFLIGHT   = 4,
  parameter int unsigned NACK_BURST_MAX = 8,
  parameter logic [18:0] START_OFFSET   = 19'h03F00,
  parameter logic [18:0] BTT            = 19'd459008
) (
  input  logic                            memclk,
  input  logic                            memrst,
  event_readout_scheduler_if.slave        bus,
  input  logic                            allow_i,
  input  logic                            stop_i,
  output logic                            stopped_o,
  output logic [12:0]                     credit_o,
  output logic [3:0]                      inflight_o,
  output logic                            err_o
);
  localparam int SW = $clog2(NACK_BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE, OFFER, STOPPED} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [12:0]   credit_q, credit_d;
  logic [3:0]    inflight_q, inflight_d;
  logic          err_q, err_d;
  logic          stopped_q, stopped_d;
  logic          req_valid_q, req_valid_d;
  logic [50:0]   req_data_q, req_data_d;

  logic        room, nack_ok, evt_ok, grant_nack, grant_evt, req_hs, sts_bad;
  logic [18:0] nack_lower, nack_btt;
  logic        unused_bits;

  assign unused_bits = ^{bus.s_sts_tdata[3:0], bus.s_nack_tdata[47],
                         bus.s_nack_tdata[45:43], bus.s_nack_tdata[19]};

  always_comb begin
    room       = inflight_q < 4'(MAX_INFLIGHT);
    nack_ok    = bus.s_nack_tvalid && room;
    evt_ok     = bus.s_evt_tvalid && (credit_q != '0) && room;
    // A full streak of nack grants yields one slot to an eligible event.
    grant_nack = (state_q == IDLE) && !stop_i && nack_ok &&
                 !(evt_ok && streak_q == SW'(NACK_BURST_MAX));
    grant_evt  = (state_q == IDLE) && !stop_i && !grant_nack && evt_ok;
    req_hs     = req_valid_q && bus.m_req_tready;
    sts_bad    = bus.s_sts_tvalid &&
                 (!bus.s_sts_tdata[7] || (|bus.s_sts_tdata[6:4]) || inflight_q == '0);
    nack_lower = bus.s_nack_tdata[18:0] + START_OFFSET;
    nack_btt   = {5'b0, bus.s_nack_tdata[42:32], 3'b000};

    state_d = state_q;
    case (state_q)
      IDLE:    if (stop_i) state_d = STOPPED;
               else if (grant_nack || grant_evt) state_d = OFFER;
      OFFER:   if (req_hs) state_d = IDLE;
      STOPPED: if (!stop_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_valid_d = (state_d == OFFER);
    stopped_d   = (state_d == STOPPED);

    req_data_d = req_data_q;
    if (grant_nack) begin
      if (bus.s_nack_tdata[46])
        req_data_d = {1'b1, bus.s_nack_tdata[31:20], START_OFFSET, BTT};
      else
        req_data_d = {1'b1, bus.s_nack_tdata[31:20], nack_lower, nack_btt};
    end else if (grant_evt) begin
      req_data_d = {1'b0, bus.s_evt_tdata, START_OFFSET, BTT};
    end

    streak_d = streak_q;
    if (grant_nack) begin
      if (streak_q != SW'(NACK_BURST_MAX)) streak_d = streak_q + SW'(1);
    end else if (grant_evt || (state_q == IDLE && !bus.s_nack_tvalid)) begin
      streak_d = '0;
    end

    credit_d = credit_q;
    if (allow_i && !grant_evt) begin
      if (credit_q != '1) credit_d = credit_q + 13'd1;
    end else if (grant_evt && !allow_i) begin
      credit_d = credit_q - 13'd1;
    end

    inflight_d = inflight_q;
    if (req_hs && !bus.s_sts_tvalid)
      inflight_d = inflight_q + 4'd1;
    else if (bus.s_sts_tvalid && !req_hs && inflight_q != '0)
      inflight_d = inflight_q - 4'd1;

    err_d = err_q || sts_bad;
  end

  always_ff @(posedge memclk or posedge memrst) begin
    if (memrst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      credit_q    <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
      stopped_q   <= 1'b0;
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      credit_q    <= credit_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
      stopped_q   <= stopped_d;
      req_valid_q <= req_valid_d;
      req_data_q  <= req_data_d;
    end
  end

  assign bus.s_evt_tready  = grant_evt;
  assign bus.s_nack_tready = grant_nack;
  assign bus.m_req_tvalid  = req_valid_q;
  assign bus.m_req_tdata   = req_data_q;
  assign stopped_o         = stopped_q;
  assign credit_o          = credit_q;
  assign inflight_o        = inflight_q;
  assign err_o             = err_q;
endmodule
